deselector: RTL and testbench

- Decompressor-side front end; inverse of the compressor's final pattern-selection stage.
- Collects one compressed block, delivered as 64-bit beats, MSB-first: LEN_ENCODE-bit select header, then payload.
- Expands the three trivial encodings itself: select 0 = all-zero, select 1 = all-word-same, select NUM_PATTERNS-1 = uncompressible/raw.
- Forwards every other block as aligned 272-bit codewords plus select for the per-pattern decoders.

---
 rtl/deselector.sv | 205 ++++++++++++++++++++
 tb/tb_deselector.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/deselector.sv
// rtl/deselector.sv - decompressor front end: collects one compressed block and expands trivial encodings
//
// Ports:
//   clk, rst_n                  clock, synchronous active-low reset
//   beat_valid_i/beat_ready_o   input beat handshake (ready is 0 while a result is held)
//   beat_first_i                beat starts a new block
//   beat_data_i                 beat payload, MSB = earliest stream bit
//   size_i                      block size in bits incl. header, sampled with the first beat
//   out_valid_o/out_ready_i     decoded block handshake
//   kind_o                      0 zero, 1 word-same, 2 raw, 3 compressed
//   select_o                    received select header
//   size_o                      clamped block size
//   line_o                      reconstructed line for kinds 0/1/2, else 0
//   codewords_o                 payload for the pattern decoders for kind 3, else 0
//   err_o                       one-cycle protocol-error pulse
module deselector #(
  parameter int NUM_PATTERNS = 8,
  parameter int LEN_ENCODE   = $clog2(NUM_PATTERNS),
  parameter int BEAT_W       = 64
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  beat_valid_i,
  output logic                  beat_ready_o,
  input  logic                  beat_first_i,
  input  logic [BEAT_W-1:0]     beat_data_i,
  input  logic [8:0]            size_i,
  output logic                  out_valid_o,
  input  logic                  out_ready_i,
  output logic [1:0]            kind_o,
  output logic [LEN_ENCODE-1:0] select_o,
  output logic [8:0]            size_o,
  output logic [255:0]          line_o,
  output logic [271:0]          codewords_o,
  output logic                  err_o
);

  localparam int NUM_SLOTS = 5;
  localparam int BUF_W     = NUM_SLOTS * BEAT_W;
  localparam int PAY_TOP   = BUF_W - 1 - LEN_ENCODE;
  localparam int BEAT_SH   = $clog2(BEAT_W);

  localparam logic [8:0] SIZE_MAX = 9'(256 + LEN_ENCODE);
  localparam logic [8:0] SIZE_MIN = 9'(LEN_ENCODE);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_COLLECT = 2'd1;
  localparam logic [1:0] S_OUT     = 2'd2;

  localparam logic [1:0] K_ZERO = 2'd0;
  localparam logic [1:0] K_SAME = 2'd1;
  localparam logic [1:0] K_RAW  = 2'd2;
  localparam logic [1:0] K_COMP = 2'd3;

  logic [1:0]            state_q, state_d;
  logic [BUF_W-1:0]      buf_q, buf_d;
  logic [2:0]            count_q, count_d;
  logic [9:0]            need_q, need_d;
  logic [8:0]            size_q, size_d;
  logic                  out_valid_q, out_valid_d;
  logic [1:0]            kind_q, kind_d;
  logic [LEN_ENCODE-1:0] select_q, select_d;
  logic [255:0]          line_q, line_d;
  logic [271:0]          cw_q, cw_d;
  logic                  err_q, err_d;

  logic                  beat_acc;
  logic [8:0]            size_c;
  logic [9:0]            need_c;
  logic                  start_blk;
  logic                  go_out;
  logic [BUF_W-1:0]      buf_n;
  logic [LEN_ENCODE-1:0] hdr;

  assign beat_ready_o = (state_q != S_OUT);
  assign beat_acc     = beat_valid_i & beat_ready_o;

  // Clamp the announced size to what the buffer can hold and to at least a header.
  always_comb begin
    size_c = size_i;
    if (size_c > SIZE_MAX) size_c = SIZE_MAX;
    if (size_c < SIZE_MIN) size_c = SIZE_MIN;
    need_c = ({1'b0, size_c} + 10'(BEAT_W - 1)) >> BEAT_SH;
  end

  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    need_d      = need_q;
    size_d      = size_q;
    out_valid_d = out_valid_q;
    kind_d      = kind_q;
    select_d    = select_q;
    line_d      = line_q;
    cw_d        = cw_q;
    err_d       = 1'b0;
    buf_n       = buf_q;
    start_blk   = 1'b0;
    go_out      = 1'b0;
    hdr         = '0;

    case (state_q)
      S_IDLE: begin
        if (beat_acc) begin
          if (beat_first_i) start_blk = 1'b1;
          else              err_d     = 1'b1;
        end
      end
      S_COLLECT: begin
        if (beat_acc) begin
          if (beat_first_i) begin
            // Abort the partial block and restart with this beat.
            err_d     = 1'b1;
            start_blk = 1'b1;
          end else begin
            for (int k = 0; k < NUM_SLOTS; k++) begin
              if (count_q == 3'(k)) buf_n[BUF_W-1-BEAT_W*k -: BEAT_W] = beat_data_i;
            end
            count_d = count_q + 3'd1;
            if (10'(count_q) + 10'd1 == need_q) go_out = 1'b1;
          end
        end
      end
      S_OUT: begin
        if (out_ready_i) begin
          out_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Clearing the buffer here makes every unreceived bit read as 0 at decode.
    if (start_blk) begin
      buf_n                       = '0;
      buf_n[BUF_W-1 -: BEAT_W]    = beat_data_i;
      size_d                      = size_c;
      need_d                      = need_c;
      count_d                     = 3'd1;
      if (need_c == 10'd1) go_out = 1'b1;
      else                 state_d = S_COLLECT;
    end

    // Decode from the buffer contents as they will be after this beat.
    if (go_out) begin
      state_d     = S_OUT;
      out_valid_d = 1'b1;
      hdr         = buf_n[BUF_W-1 -: LEN_ENCODE];
      select_d    = hdr;
      line_d      = '0;
      cw_d        = '0;
      if (hdr == LEN_ENCODE'(0)) begin
        kind_d = K_ZERO;
      end else if (hdr == LEN_ENCODE'(1)) begin
        kind_d = K_SAME;
        line_d = {8{buf_n[PAY_TOP -: 32]}};
      end else if (hdr == LEN_ENCODE'(NUM_PATTERNS - 1)) begin
        kind_d = K_RAW;
        line_d = buf_n[PAY_TOP -: 256];
      end else begin
        kind_d = K_COMP;
        cw_d   = buf_n[PAY_TOP -: 272];
      end
    end

    buf_d = buf_n;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      buf_q       <= '0;
      count_q     <= '0;
      need_q      <= '0;
      size_q      <= '0;
      out_valid_q <= 1'b0;
      kind_q      <= '0;
      select_q    <= '0;
      line_q      <= '0;
      cw_q        <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      buf_q       <= buf_d;
      count_q     <= count_d;
      need_q      <= need_d;
      size_q      <= size_d;
      out_valid_q <= out_valid_d;
      kind_q      <= kind_d;
      select_q    <= select_d;
      line_q      <= line_d;
      cw_q        <= cw_d;
      err_q       <= err_d;
    end
  end

  assign out_valid_o = out_valid_q;
  assign kind_o      = kind_q;
  assign select_o    = select_q;
  assign size_o      = size_q;
  assign line_o      = line_q;
  assign codewords_o = cw_q;
  assign err_o       = err_q;

endmodule

// File: tb/tb_deselector.sv
// tb/tb_deselector.sv - self-checking bench for deselector
module tb_deselector;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         beat_valid_i;
  logic         beat_ready_o;
  logic         beat_first_i;
  logic [63:0]  beat_data_i;
  logic [8:0]   size_i;
  logic         out_valid_o;
  logic         out_ready_i;
  logic [1:0]   kind_o;
  logic [2:0]   select_o;
  logic [8:0]   size_o;
  logic [255:0] line_o;
  logic [271:0] codewords_o;
  logic         err_o;

  always #5 clk = ~clk;

  deselector dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .beat_valid_i (beat_valid_i),
    .beat_ready_o (beat_ready_o),
    .beat_first_i (beat_first_i),
    .beat_data_i  (beat_data_i),
    .size_i       (size_i),
    .out_valid_o  (out_valid_o),
    .out_ready_i  (out_ready_i),
    .kind_o       (kind_o),
    .select_o     (select_o),
    .size_o       (size_o),
    .line_o       (line_o),
    .codewords_o  (codewords_o),
    .err_o        (err_o)
  );

  typedef struct {
    string        name;
    logic [319:0] stream;
    int           nbeats;
    logic [8:0]   size;
    int           hold;
    logic [1:0]   kind;
    logic [2:0]   sel;
    logic [8:0]   osize;
    logic [255:0] line;
    logic [271:0] cw;
  } vec_t;

  vec_t vecs[7];
  int   n_pass = 0;
  int   n_total = 0;

  localparam logic [255:0] RAW_PAY =
    256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [196:0] P197 = {5'h15, {12{16'hC3A5}}};

  task automatic chk(input string nm, input logic [319:0] act, input logic [319:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  function automatic logic [63:0] beat_of(input logic [319:0] s, input int k);
    logic [319:0] t;
    t = s << (64 * k);
    return t[319:256];
  endfunction

  function automatic vec_t mk(input string nm, input logic [319:0] s, input int nb,
                              input logic [8:0] sz, input int hold, input logic [1:0] kind,
                              input logic [2:0] sel, input logic [8:0] osz,
                              input logic [255:0] line, input logic [271:0] cw);
    vec_t v;
    v.name = nm; v.stream = s; v.nbeats = nb; v.size = sz; v.hold = hold;
    v.kind = kind; v.sel = sel; v.osize = osz; v.line = line; v.cw = cw;
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_vec(input int i);
    vec_t v;
    v = vecs[i];
    for (int b = 0; b < v.nbeats; b++) begin
      beat_valid_i = 1'b1;
      beat_first_i = (b == 0);
      beat_data_i  = beat_of(v.stream, b);
      size_i       = v.size;
      chk({v.name, ".ready"}, 320'(beat_ready_o), 320'(1));
      tick();
      if (b < v.nbeats - 1) chk({v.name, ".early_valid"}, 320'(out_valid_o), 320'(0));
    end
    beat_valid_i = 1'b0;
    beat_first_i = 1'b0;
    chk({v.name, ".valid"},  320'(out_valid_o),  320'(1));
    chk({v.name, ".kind"},   320'(kind_o),       320'(v.kind));
    chk({v.name, ".select"}, 320'(select_o),     320'(v.sel));
    chk({v.name, ".size"},   320'(size_o),       320'(v.osize));
    chk({v.name, ".line"},   320'(line_o),       320'(v.line));
    chk({v.name, ".cw"},     320'(codewords_o),  320'(v.cw));
    chk({v.name, ".err"},    320'(err_o),        320'(0));
    chk({v.name, ".ready_out"}, 320'(beat_ready_o), 320'(0));
    for (int h = 0; h < v.hold; h++) begin
      tick();
      chk({v.name, ".hold_valid"}, 320'(out_valid_o),  320'(1));
      chk({v.name, ".hold_ready"}, 320'(beat_ready_o), 320'(0));
      chk({v.name, ".hold_line"},  320'(line_o),       320'(v.line));
      chk({v.name, ".hold_kind"},  320'(kind_o),       320'(v.kind));
    end
    out_ready_i = 1'b1;
    tick();
    out_ready_i = 1'b0;
    chk({v.name, ".done_valid"}, 320'(out_valid_o),  320'(0));
    chk({v.name, ".done_ready"}, 320'(beat_ready_o), 320'(1));
  endtask

  initial begin
    vecs[0] = mk("zero", 320'b0, 1, 9'd3, 0, 2'd0, 3'd0, 9'd3, '0, '0);
    vecs[1] = mk("same", {3'b001, 32'hDEADBEEF, 285'b0}, 1, 9'd35, 5, 2'd1, 3'd1, 9'd35,
                 {8{32'hDEADBEEF}}, '0);
    vecs[2] = mk("raw", {3'b111, RAW_PAY, 61'b0}, 5, 9'd259, 0, 2'd2, 3'd7, 9'd259, RAW_PAY, '0);
    vecs[3] = mk("raw400", {3'b111, RAW_PAY, 61'b0}, 5, 9'd400, 0, 2'd2, 3'd7, 9'd259, RAW_PAY, '0);
    vecs[4] = mk("comp200", {3'b010, P197, 120'b0}, 4, 9'd200, 0, 2'd3, 3'd2, 9'd200, '0,
                 {P197, 75'b0});
    vecs[5] = mk("comp_min", {3'b101, 61'h1BCDEF0123456789, 256'b0}, 1, 9'd1, 0, 2'd3, 3'd5, 9'd3,
                 '0, {61'h1BCDEF0123456789, 211'b0});
    vecs[6] = mk("comp300", {3'b110, {17{16'hA55A}}, 45'h1FFFFFFFFFFF}, 5, 9'd300, 1, 2'd3, 3'd6,
                 9'd259, '0, {17{16'hA55A}});

    rst_n = 1'b0; beat_valid_i = 1'b0; beat_first_i = 1'b0; beat_data_i = '0;
    size_i = '0; out_ready_i = 1'b0;
    tick();
    chk("rst.valid", 320'(out_valid_o),  320'(0));
    chk("rst.ready", 320'(beat_ready_o), 320'(1));
    chk("rst.err",   320'(err_o),        320'(0));
    chk("rst.size",  320'(size_o),       320'(0));
    chk("rst.line",  320'(line_o),       320'(0));
    chk("rst.cw",    320'(codewords_o),  320'(0));
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < 7; i++) run_vec(i);

    // Abort: new first beat at beat 2 of a raw block.
    beat_valid_i = 1'b1; beat_first_i = 1'b1; size_i = 9'd259;
    beat_data_i = beat_of(vecs[2].stream, 0);
    tick();
    chk("abort.err_before", 320'(err_o), 320'(0));
    beat_data_i = 64'h0; size_i = 9'd3;
    tick();
    beat_valid_i = 1'b0; beat_first_i = 1'b0;
    chk("abort.err",   320'(err_o),       320'(1));
    chk("abort.valid", 320'(out_valid_o), 320'(1));
    chk("abort.kind",  320'(kind_o),      320'(0));
    chk("abort.size",  320'(size_o),      320'(3));
    chk("abort.line",  320'(line_o),      320'(0));
    out_ready_i = 1'b1;
    tick();
    out_ready_i = 1'b0;
    chk("abort.err_once", 320'(err_o),       320'(0));
    chk("abort.done",     320'(out_valid_o), 320'(0));

    // Non-first beat while idle is dropped.
    beat_valid_i = 1'b1; beat_first_i = 1'b0; beat_data_i = 64'hFFFF_0000_FFFF_0000;
    tick();
    beat_valid_i = 1'b0;
    chk("stray.err",   320'(err_o),        320'(1));
    chk("stray.valid", 320'(out_valid_o),  320'(0));
    chk("stray.ready", 320'(beat_ready_o), 320'(1));
    tick();
    chk("stray.err_once", 320'(err_o),       320'(0));
    chk("stray.valid2",   320'(out_valid_o), 320'(0));

    // Reset in the middle of collection.
    beat_valid_i = 1'b1; size_i = 9'd259;
    for (int b = 0; b < 2; b++) begin
      beat_first_i = (b == 0);
      beat_data_i  = beat_of(vecs[2].stream, b);
      tick();
    end
    beat_valid_i = 1'b0; beat_first_i = 1'b0;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("mrst.valid", 320'(out_valid_o),  320'(0));
    chk("mrst.ready", 320'(beat_ready_o), 320'(1));
    chk("mrst.size",  320'(size_o),       320'(0));
    chk("mrst.kind",  320'(kind_o),       320'(0));
    chk("mrst.line",  320'(line_o),       320'(0));
    tick();
    chk("mrst.no_out", 320'(out_valid_o), 320'(0));
    run_vec(4);
    run_vec(2);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
